// File: rtl/plic_claim_agent.sv
// Hart-side PLIC claim/complete initiator: claims an ID over APB4 from CLAIMCOMP,
// hands it to a local handler, and writes it back once the handler reports done.
module plic_claim_agent #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          IRQ_WIDTH   = 5,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 ext_irq_i,
  output logic [31:0]          paddr_o,
  output logic [2:0]           pprot_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [31:0]          pwdata_o,
  output logic [3:0]           pstrb_o,
  input  logic                 pready_i,
  input  logic [31:0]          prdata_i,
  input  logic                 pslverr_i,
  output logic                 irq_valid_o,
  output logic [IRQ_WIDTH-1:0] irq_id_o,
  input  logic                 irq_ready_i,
  input  logic                 done_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [7:0]           spur_cnt_o
);

  localparam int              CW         = (TIMEOUT_CYC <= 255) ? 8 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0]     CLAIM_ADDR = BASE_ADDR + 32'h24;
  localparam logic [CW-1:0]   TO_LAST    = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CLM_SETUP, CLM_ACCESS, DELIVER, SERVICE, CMP_SETUP, CMP_ACCESS
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [31:0]          paddr_q;
  logic [31:0]          pwdata_q;
  logic [3:0]           pstrb_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic                 irq_valid_q;
  logic [IRQ_WIDTH-1:0] irq_id_q;
  logic                 err_q;
  logic [7:0]           spur_q;

  logic                 to_hit;
  logic [IRQ_WIDTH-1:0] rd_id;
  logic                 unused_prdata;

  assign to_hit        = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
  assign rd_id         = prdata_i[IRQ_WIDTH-1:0];
  assign unused_prdata = ^prdata_i[31:IRQ_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      err_q       <= 1'b0;
      spur_q      <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_i && ext_irq_i) begin
            state_q  <= CLM_SETUP;
            cnt_q    <= '0;
            psel_q   <= 1'b1;
            pwrite_q <= 1'b0;
            paddr_q  <= CLAIM_ADDR;
            pstrb_q  <= 4'b0000;
          end
        end
        CLM_SETUP: begin
          state_q   <= CLM_ACCESS;
          penable_q <= 1'b1;
        end
        DELIVER: begin
          if (irq_ready_i) begin
            irq_valid_q <= 1'b0;
            if (done_i) begin
              state_q  <= CMP_SETUP;
              cnt_q    <= '0;
              psel_q   <= 1'b1;
              pwrite_q <= 1'b1;
              paddr_q  <= CLAIM_ADDR;
              pwdata_q <= 32'(irq_id_q);
              pstrb_q  <= 4'b1111;
            end else begin
              state_q <= SERVICE;
            end
          end
        end
        SERVICE: begin
          if (done_i) begin
            state_q  <= CMP_SETUP;
            cnt_q    <= '0;
            psel_q   <= 1'b1;
            pwrite_q <= 1'b1;
            paddr_q  <= CLAIM_ADDR;
            pwdata_q <= 32'(irq_id_q);
            pstrb_q  <= 4'b1111;
          end
        end
        CMP_SETUP: begin
          state_q   <= CMP_ACCESS;
          penable_q <= 1'b1;
        end
        CLM_ACCESS, CMP_ACCESS: begin
          // pready wins over a timeout landing in the same cycle
          if (pready_i || to_hit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            state_q   <= IDLE;
            if (!pready_i || pslverr_i) begin
              err_q <= 1'b1;
            end else if (state_q == CLM_ACCESS) begin
              if (rd_id == '0) begin
                if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
              end else begin
                irq_id_q    <= rd_id;
                irq_valid_q <= 1'b1;
                state_q     <= DELIVER;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign paddr_o     = paddr_q;
  assign pprot_o     = 3'b000;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign spur_cnt_o  = spur_q;

endmodule

// File: tb/tb_plic_claim_agent.sv
// Randomized episodes of claim/deliver/complete against a transaction-level
// expectation of the claim agent, plus directed corner cases.
module tb_plic_claim_agent;

  localparam logic [31:0] BASE  = 32'h0C00_0000;
  localparam logic [31:0] CLAIM = BASE + 32'h24;
  localparam int          TO    = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i, ext_irq_i;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic [2:0]  pprot_o;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
  logic [3:0]  pstrb_o;
  logic        irq_valid_o, irq_ready_i, done_i, busy_o, err_o;
  logic [4:0]  irq_id_o;
  logic [7:0]  spur_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int spur_m = 0;

  plic_claim_agent #(.BASE_ADDR(BASE), .IRQ_WIDTH(5), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .ext_irq_i(ext_irq_i),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i),
    .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_ready_i(irq_ready_i),
    .done_i(done_i), .busy_o(busy_o), .err_o(err_o), .spur_cnt_o(spur_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One APB transfer as seen by the slave: setup, `waits` low-ready cycles, then
  // a response; a run of TO low-ready cycles is expected to abort with err_o.
  task automatic apb_phase(input bit wr, input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata, input bit serr, output int oc);
    int n;
    n  = 0;
    oc = 0;
    while (!psel_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    if (!psel_o) begin
      chk("psel_start", psel_o, 1);
      oc = 2;
      return;
    end
    ext_irq_i = 1'b0;
    chk("setup_penable", penable_o, 0);
    chk("setup_paddr", paddr_o, CLAIM);
    chk("setup_pwrite", pwrite_o, wr);
    chk("setup_pstrb", pstrb_o, wr ? 4'hF : 4'h0);
    chk("pprot", pprot_o, 0);
    if (wr) chk("setup_pwdata", pwdata_o, wdata);
    @(negedge clk_i);
    for (int i = 0; i < 64; i++) begin
      chk("acc_psel", psel_o, 1);
      chk("acc_penable", penable_o, 1);
      chk("acc_paddr", paddr_o, CLAIM);
      chk("acc_pwrite", pwrite_o, wr);
      chk("acc_err", err_o, 0);
      if (wr) chk("acc_pwdata", pwdata_o, wdata);
      pready_i  = (i == waits);
      prdata_i  = (i == waits) ? rdata : $urandom;
      pslverr_i = (i == waits) && serr;
      @(negedge clk_i);
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      if (i == waits || i == TO - 1) break;
    end
    chk("end_psel", psel_o, 0);
    chk("end_penable", penable_o, 0);
    chk("err_o", err_o, (waits >= TO) || serr);
  endtask

  // Full interrupt episode; expected outcome derived from the protocol rules.
  task automatic episode(input int wc, input logic [31:0] rd, input bit serr,
                         input int dly, input bit comb, input int svc,
                         input int wp, input bit serr_p);
    int         start, oc;
    logic [4:0] id;
    bit         ok, deliv;
    en_i      = 1'b1;
    ext_irq_i = 1'b1;
    start     = cyc;
    apb_phase(1'b0, 32'h0, wc, rd, serr, oc);
    if (oc == 2) return;
    id    = rd[4:0];
    ok    = !serr && (wc < TO);
    deliv = ok && (id != 5'd0);
    if (ok && id == 5'd0) spur_m = (spur_m == 255) ? 255 : spur_m + 1;
    chk("spur_cnt", spur_cnt_o, spur_m);
    chk("irq_valid", irq_valid_o, deliv);
    chk("busy_claim", busy_o, deliv);
    if (!deliv) begin
      @(negedge clk_i);
      chk("err_pulse_end", err_o, 0);
      chk("no_valid_late", irq_valid_o, 0);
      return;
    end
    chk("irq_id", irq_id_o, id);
    chk("latency", cyc - start, 3 + wc);
    en_i = 1'($urandom_range(0, 1));
    for (int k = 0; k < dly; k++) begin
      @(negedge clk_i);
      chk("valid_hold", irq_valid_o, 1);
      chk("id_hold", irq_id_o, id);
    end
    irq_ready_i = 1'b1;
    done_i      = comb;
    @(negedge clk_i);
    irq_ready_i = 1'b0;
    done_i      = 1'b0;
    chk("valid_drop", irq_valid_o, 0);
    chk("cmp_direct", psel_o, comb);
    if (!comb) begin
      for (int k = 0; k < svc; k++) begin
        @(negedge clk_i);
        chk("svc_no_apb", psel_o, 0);
        chk("svc_busy", busy_o, 1);
      end
      done_i = 1'b1;
      @(negedge clk_i);
      done_i = 1'b0;
      chk("cmp_setup", psel_o, 1);
    end
    apb_phase(1'b1, {27'b0, id}, wp, $urandom, serr_p, oc);
    if (oc == 2) return;
    chk("busy_end", busy_o, 0);
    @(negedge clk_i);
    chk("err_pulse_end2", err_o, 0);
    chk("idle_after_cmp", psel_o, 0);
  endtask

  initial begin
    int         oc;
    logic [31:0] rd;
    rst_i = 1'b1; en_i = 1'b0; ext_irq_i = 1'b0; prdata_i = '0;
    pready_i = 1'b0; pslverr_i = 1'b0; irq_ready_i = 1'b0; done_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pstrb", pstrb_o, 0);
    chk("rst_valid", irq_valid_o, 0);
    chk("rst_id", irq_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_spur", spur_cnt_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // directed: basic, wait states, slverr, complete timeout, ready+done together
    episode(0, 32'h0000_0007, 0, 1, 0, 2, 0, 0);
    episode(4, 32'hABCD_0013, 0, 0, 0, 1, 4, 0);
    episode(0, 32'h0000_0005, 1, 0, 0, 0, 0, 0);
    episode(0, 32'h0000_0003, 0, 0, 0, 0, 9, 0);
    episode(1, 32'h0000_001F, 0, 0, 1, 0, 0, 0);
    episode(8, 32'h0000_0004, 0, 0, 0, 0, 0, 0);
    episode(2, 32'h0000_0009, 0, 2, 0, 0, 1, 1);

    // disabled agent ignores ext_irq; done in IDLE causes no activity
    en_i = 1'b0; ext_irq_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("disabled_no_apb", psel_o, 0);
    end
    ext_irq_i = 1'b0; en_i = 1'b1; done_i = 1'b1;
    @(negedge clk_i);
    done_i = 1'b0;
    repeat (3) begin
      chk("idle_done_no_apb", psel_o, 0);
      chk("idle_done_busy", busy_o, 0);
      @(negedge clk_i);
    end

    for (int e = 0; e < 60; e++) begin
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) rd[4:0] = 5'd0;
      episode(($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 4),
              rd, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 4),
              ($urandom_range(0, 7) == 0));
    end

    // spurious claims until the counter saturates
    for (int e = 0; e < 300; e++) begin
      rd = $urandom;
      rd[4:0] = 5'd0;
      episode(0, rd, 0, 0, 0, 0, 0, 0);
    end
    chk("spur_saturated", spur_cnt_o, 255);

    // async reset during claim access phase
    en_i = 1'b1; ext_irq_i = 1'b1;
    apb_phase(1'b0, 32'h0, 100, 32'h0, 0, oc);
    // apb_phase aborted by timeout here; start another and cut it with reset
    @(negedge clk_i);
    ext_irq_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_penable", penable_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_psel", psel_o, 0);
    chk("async_rst_penable", penable_o, 0);
    chk("async_rst_busy", busy_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i  = 1'b0;
    spur_m = 0;
    chk("post_rst_spur", spur_cnt_o, 0);
    episode(0, 32'h0000_000B, 0, 0, 0, 1, 0, 0);
    episode(3, 32'h0000_0011, 0, 1, 1, 0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
